// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues one instruction-SRAM request at a time and
// hands {inst, pc} to IF, absorbing branch/flush redirects that arrive mid-transaction.
module pre_if_stage (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        if_allowin,
  output logic        pre_if_to_if_valid,
  output logic [63:0] pre_if_to_if_data,
  output logic        pre_if_to_if_excep
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        discard_q, discard_d;
  logic        redir_valid_q, redir_valid_d;
  logic        buf_adef_q, buf_adef_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        pc_aligned;
  logic        out_valid;

  assign redirect    = flush | br_taken;
  assign redirect_pc = flush ? flush_target : br_target;
  assign pc_aligned  = (fetch_pc_q[1:0] == 2'b00);
  assign out_valid   = (state_q == ST_HOLD) & ~redirect;

  assign inst_sram_req      = resetn & (state_q == ST_REQ) & pc_aligned;
  assign inst_sram_wr       = 1'b0;
  assign inst_sram_size     = 2'b10;
  assign inst_sram_wstrb    = 4'b0000;
  assign inst_sram_wdata    = 32'h0000_0000;
  assign inst_sram_addr     = fetch_pc_q;
  assign pre_if_to_if_valid = resetn & out_valid;
  assign pre_if_to_if_data  = {buf_inst_q, fetch_pc_q};
  assign pre_if_to_if_excep = resetn & buf_adef_q;

  // Next-state logic for the fetch FSM and its redirect bookkeeping
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redir_pc_d    = redir_pc_q;
    buf_inst_d    = buf_inst_q;
    discard_d     = discard_q;
    redir_valid_d = redir_valid_q;
    buf_adef_d    = buf_adef_q;
    case (state_q)
      ST_REQ: begin
        if (!pc_aligned) begin
          // Misaligned PC never reaches the bus; it becomes an ADEF bundle unless redirected.
          if (redirect) begin
            fetch_pc_d = redirect_pc;
          end else begin
            state_d    = ST_HOLD;
            buf_inst_d = 32'h0000_0000;
            buf_adef_d = 1'b1;
          end
        end else if (inst_sram_addr_ok) begin
          state_d = ST_WAIT;
          if (redirect) begin
            discard_d     = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = redirect_pc;
          end else if (redir_valid_q) begin
            discard_d = 1'b1;
          end else begin
            discard_d = 1'b0;
          end
        end else if (redirect) begin
          // The address must stay put until accepted, so the redirect waits its turn.
          redir_valid_d = 1'b1;
          redir_pc_d    = redirect_pc;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (inst_sram_data_ok) begin
          if (redirect) begin
            state_d       = ST_REQ;
            fetch_pc_d    = redirect_pc;
            discard_d     = 1'b0;
            redir_valid_d = 1'b0;
          end else if (discard_q) begin
            state_d       = ST_REQ;
            fetch_pc_d    = redir_pc_q;
            discard_d     = 1'b0;
            redir_valid_d = 1'b0;
          end else begin
            state_d    = ST_HOLD;
            buf_inst_d = inst_sram_rdata;
            buf_adef_d = 1'b0;
          end
        end else if (redirect) begin
          discard_d     = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = redirect_pc;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d    = ST_REQ;
          fetch_pc_d = redirect_pc;
        end else if (if_allowin) begin
          state_d    = ST_REQ;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_REQ;
      fetch_pc_q    <= RESET_PC;
      redir_pc_q    <= 32'h0000_0000;
      buf_inst_q    <= 32'h0000_0000;
      discard_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      buf_adef_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redir_pc_q    <= redir_pc_d;
      buf_inst_q    <= buf_inst_d;
      discard_q     <= discard_d;
      redir_valid_q <= redir_valid_d;
      buf_adef_q    <= buf_adef_d;
    end
  end

endmodule

// File: doc/pre_if_stage.md
PRE_IF_STAGE -- requirements
Module: pre_if_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
  - clk  in  1  clock
  - resetn  in  1  synchronous active-low reset
  - inst_sram_req  out  1  fetch request
  - inst_sram_wr  out  1  write flag, constant 0
  - inst_sram_size  out  2  transfer size, constant 2'b10
  - inst_sram_wstrb  out  4  write strobe, constant 0
  - inst_sram_addr  out  32  fetch address
  - inst_sram_wdata  out  32  write data, constant 0
  - inst_sram_addr_ok  in  1  request accepted
  - inst_sram_data_ok  in  1  read data valid
  - inst_sram_rdata  in  32  instruction
  - br_taken  in  1  single-cycle redirect from ID
  - br_target  in  32  branch target
  - flush  in  1  single-cycle redirect from WB (exception/ertn)
  - flush_target  in  32  ex_entry or era
  - if_allowin  in  1  IF can accept
  - pre_if_to_if_valid  out  1  bundle valid
  - pre_if_to_if_data  out  64  {inst[63:32], pc[31:0]}
  - pre_if_to_if_excep  out  1  ADEF flag
REQ-002 SHALL state: reset resetn, synchronous, active-low; clock clk.

Function
REQ-003 SHALL hold fetch_pc (32b), state (REQ/WAIT/HOLD), discard (1b), redir_valid (1b), redir_pc (32b), buf_inst (32b), buf_adef (1b).
REQ-004 SHALL allow at most one outstanding request.
REQ-005 SHALL drive inst_sram_addr = fetch_pc.
REQ-006 REQ state SHALL assert inst_sram_req iff fetch_pc[1:0]==0.
REQ-007 REQ, fetch_pc[1:0]!=0 -> next HOLD, buf_inst=0, buf_adef=1, no bus request.
REQ-008 REQ, addr_ok=1 -> next WAIT.
REQ-009 Once req is high, addr SHALL stay stable until addr_ok; redirects during this window are latched, not applied.
REQ-010 WAIT, data_ok=1, discard=0 -> capture rdata into buf_inst, buf_adef=0, next HOLD.
REQ-011 WAIT, data_ok=1, discard=1 -> drop data, clear discard, fetch_pc=redir_pc, clear redir_valid, next REQ.
REQ-012 HOLD: pre_if_to_if_valid = ~flush & ~br_taken.
REQ-013 pre_if_to_if_data = {buf_inst, fetch_pc}; pre_if_to_if_excep = buf_adef.
REQ-014 HOLD, valid & if_allowin -> fetch_pc += 4 (mod 2^32, wraps), next REQ; request issues the following cycle.
REQ-015 Redirect target SHALL be flush_target if flush=1, else br_target if br_taken=1; flush wins when both are asserted.
REQ-016 Redirect in REQ with req low, or in REQ with req high and no addr_ok -> see REQ-017/018.
REQ-017 Redirect in REQ, req low (including ADEF PC) -> fetch_pc = target next cycle, stay REQ.
REQ-018 Redirect in REQ, req high, no addr_ok -> latch redir_pc/redir_valid; on later addr_ok set discard=1 and go to WAIT.
REQ-019 Redirect in REQ with addr_ok same cycle, or in WAIT without data_ok -> discard=1, latch redir_pc, stay/go WAIT.
REQ-020 Redirect in WAIT with data_ok same cycle -> drop data, fetch_pc=target, next REQ.
REQ-021 Redirect in HOLD -> drop buffer, fetch_pc=target, next REQ, no output transfer.
REQ-022 A later redirect SHALL overwrite a pending redir_pc.
REQ-023 Latency: addr_ok in cycle T, data_ok in T+k -> pre_if_to_if_valid in T+k+1.
REQ-024 A discarded response SHALL never appear on the output.

Reset
REQ-025 resetn=0 -> state REQ, fetch_pc=32'h1C00_0000, discard=0, redir_valid=0, buf_inst=0, buf_adef=0.
REQ-026 During reset: inst_sram_req=0, pre_if_to_if_valid=0, excep=0.
REQ-027 First request SHALL issue in the first cycle after resetn rises.
REQ-028 Reset mid-transaction SHALL abandon the outstanding response; the bus is reset together with this block.

Verification
REQ-029 Reset release, addr_ok immediate, data_ok 2 cycles later, rdata=0x02800C21 -> valid with data {0x02800C21, 0x1C000000}, then next req addr 0x1C000004.
REQ-030 if_allowin=0 for 5 cycles in HOLD -> valid held, data stable, no new req; allowin=1 -> transfer, addr +4.
REQ-031 br_taken target 0x1C000100 while WAIT -> old data_ok dropped, next req addr 0x1C000100, no stale output.
REQ-032 flush target 0x1C008000 and br_taken target 0x1C000200 in the same cycle -> next fetch at 0x1C008000.
REQ-033 br_target 0x1C000102 -> no req, valid with excep=1, inst=0, pc 0x1C000102.
REQ-034 fetch_pc 0xFFFFFFFC transferred -> next addr 0x00000000.
